// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit
// Load/store front-end that sits between the pipeline MEM stage and a
// word-wide data RAM. The RAM has a synchronous write, a combinational read
// and accepts only whole-word writes. Each request is byte addressed and
// accepted over a valid/ready handshake. Loads are extracted and sign- or
// zero-extended. Byte and halfword stores are done by read-modify-write.
// Misaligned or illegal accesses are flagged and never touch the RAM.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RST_N        synchronous active-low reset
//   REQ_VALID    request present
//   REQ_READY    unit can accept a request (high only when idle)
//   REQ_WRITE    1 = store, 0 = load
//   REQ_FUNCT3   RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   REQ_ADDR     byte address
//   REQ_WDATA    store data (low byte/half used for sb/sh)
//   RESP_VALID   one-cycle completion pulse
//   RESP_DATA    extended load result, 0 for stores and errors
//   RESP_ERR     misaligned/illegal access, valid with RESP_VALID
//   MEM_ADDRESS  RAM word index
//   MEM_WRITE    RAM write enable
//   MEM_WDATA    RAM write data
//   MEM_RDATA    RAM combinational read data
module data_mem_access_unit #(
    parameter int ADDRESS_SIZE = 1024,
    localparam int A_S = $clog2(ADDRESS_SIZE)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           REQ_VALID,
    output logic           REQ_READY,
    input  logic           REQ_WRITE,
    input  logic [2:0]     REQ_FUNCT3,
    input  logic [31:0]    REQ_ADDR,
    input  logic [31:0]    REQ_WDATA,
    output logic           RESP_VALID,
    output logic [31:0]    RESP_DATA,
    output logic           RESP_ERR,
    output logic [A_S-1:0] MEM_ADDRESS,
    output logic           MEM_WRITE,
    output logic [31:0]    MEM_WDATA,
    input  logic [31:0]    MEM_RDATA
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_ERROR
    } state_t;

    state_t         state;
    logic           req_write;
    logic [2:0]     funct3;
    logic [A_S+1:0] addr;
    logic [31:0]    wdata;
    logic [31:0]    merge;

    // Address bits above the RAM index are deliberately dropped so that
    // accesses wrap modulo the RAM size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^REQ_ADDR[31:A_S+2];

    // Decide whether a request is illegal from its direction, width code and
    // low address bits.
    function automatic logic is_illegal(input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a != 2'b00);
            3'b100:  bad = wr;
            3'b101:  bad = wr | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pick the addressed byte/half out of the RAM word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  a,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        b = rdata[{a, 3'b000} +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  result = {{24{b[7]}}, b};
            3'b001:  result = {{16{h[15]}}, h};
            3'b100:  result = {24'h0, b};
            3'b101:  result = {16'h0, h};
            default: result = rdata;
        endcase
        return result;
    endfunction

    assign REQ_READY   = (state == S_IDLE);
    assign MEM_ADDRESS = addr[A_S+1:2];

    // Gating with RST_N keeps a write from landing at the edge where reset
    // is sampled, so an abandoned store leaves the RAM untouched.
    assign MEM_WRITE = (state == S_WRITE) && RST_N;

    // Write data: the word captured during READ with the addressed lane
    // replaced; a full-word store bypasses the merge and uses wdata directly.
    always_comb begin
        MEM_WDATA = merge;
        case (funct3[1:0])
            2'b00: MEM_WDATA[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (addr[1]) begin
                    MEM_WDATA[31:16] = wdata[15:0];
                end else begin
                    MEM_WDATA[15:0] = wdata[15:0];
                end
            end
            default: MEM_WDATA = wdata;
        endcase
    end

    // Transaction FSM. Responses are one-cycle pulses, so RESP_VALID and
    // RESP_ERR default low each cycle; RESP_DATA holds its last value.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            RESP_VALID <= 1'b0;
            RESP_ERR   <= 1'b0;
            RESP_DATA  <= 32'h0;
            req_write  <= 1'b0;
            funct3     <= 3'b000;
            addr       <= '0;
            wdata      <= 32'h0;
            merge      <= 32'h0;
        end else begin
            RESP_VALID <= 1'b0;
            RESP_ERR   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        req_write <= REQ_WRITE;
                        funct3    <= REQ_FUNCT3;
                        addr      <= REQ_ADDR[A_S+1:0];
                        wdata     <= REQ_WDATA;
                        if (is_illegal(REQ_WRITE, REQ_FUNCT3, REQ_ADDR[1:0])) begin
                            state <= S_ERROR;
                        end else if (REQ_WRITE && (REQ_FUNCT3 == 3'b010)) begin
                            state <= S_WRITE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (req_write) begin
                        merge <= MEM_RDATA;
                        state <= S_WRITE;
                    end else begin
                        RESP_DATA  <= load_extend(funct3, addr[1:0], MEM_RDATA);
                        RESP_VALID <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    RESP_VALID <= 1'b1;
                    RESP_DATA  <= 32'h0;
                    state      <= S_IDLE;
                end
                S_ERROR: begin
                    RESP_VALID <= 1'b1;
                    RESP_ERR   <= 1'b1;
                    RESP_DATA  <= 32'h0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb_data_mem_access_unit
// Self-checking bench for data_mem_access_unit. A behavioural word RAM is
// attached to the memory port; an independent reference model computes the
// expected response, latency, write count and RAM contents for every request
// from the access rules using plain arithmetic on its own copy of memory.
module tb_data_mem_access_unit;

    localparam int DEPTH = 1024;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WRITE;
    logic [2:0]  REQ_FUNCT3;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RESP_VALID;
    logic [31:0] RESP_DATA;
    logic        RESP_ERR;
    logic [9:0]  MEM_ADDRESS;
    logic        MEM_WRITE;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;

    int checks = 0;
    int failures = 0;
    int write_count = 0;
    int accept_count = 0;
    logic [31:0] last_data;

    logic [31:0] ram [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    data_mem_access_unit #(.ADDRESS_SIZE(DEPTH)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .REQ_VALID   (REQ_VALID),
        .REQ_READY   (REQ_READY),
        .REQ_WRITE   (REQ_WRITE),
        .REQ_FUNCT3  (REQ_FUNCT3),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .RESP_VALID  (RESP_VALID),
        .RESP_DATA   (RESP_DATA),
        .RESP_ERR    (RESP_ERR),
        .MEM_ADDRESS (MEM_ADDRESS),
        .MEM_WRITE   (MEM_WRITE),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_RDATA   (MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    // Word RAM: combinational read, write on the rising edge.
    assign MEM_RDATA = ram[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (MEM_WRITE) begin
            ram[MEM_ADDRESS] = MEM_WDATA;
            write_count++;
        end
    end

    // Handshake observer: counts accepted requests.
    always @(posedge CLK) begin
        if (RST_N && REQ_VALID && REQ_READY) begin
            accept_count++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model: expected outcome of one request, updating ref_mem.
    task automatic ref_access(input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] exp_data, output logic exp_err,
                              output int exp_lat, output int exp_writes);
        int unsigned idx, off, sh;
        logic [31:0] word, v, mask;
        bit illegal;
        idx = (addr / 4) % DEPTH;
        off = addr % 4;
        sh  = off * 8;
        illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (wr && f3 >= 4) ||
                  ((f3 == 1 || f3 == 5) && (off % 2 != 0)) || (f3 == 2 && off != 0);
        exp_data = 32'h0;
        exp_err = 1'b0;
        exp_lat = 2;
        exp_writes = 0;
        word = ref_mem[idx];
        if (illegal) begin
            exp_err = 1'b1;
        end else if (wr) begin
            exp_writes = 1;
            if (f3 == 2) begin
                ref_mem[idx] = wdata;
            end else begin
                exp_lat = 3;
                mask = (f3 == 0) ? (32'hFF << sh) : (32'hFFFF << sh);
                ref_mem[idx] = (word & ~mask) | ((wdata << sh) & mask);
            end
        end else begin
            v = word >> sh;
            case (f3)
                3'd0: begin
                    v = v & 32'hFF;
                    if (v >= 32'h80) v = v + 32'hFFFFFF00;
                end
                3'd1: begin
                    v = v & 32'hFFFF;
                    if (v >= 32'h8000) v = v + 32'hFFFF0000;
                end
                3'd4: v = v & 32'hFF;
                3'd5: v = v & 32'hFFFF;
                default: v = word;
            endcase
            exp_data = v;
        end
    endtask

    // Issue one request (starting just after a clock edge), wait a bounded
    // number of edges for the response and compare it with the model.
    task automatic apply_stimulus(input string tag, input logic wr,
                                  input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input bit hold);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat, exp_writes, lat, wc0;
        int unsigned idx;
        ref_access(wr, f3, addr, wdata, exp_data, exp_err, exp_lat, exp_writes);
        idx = (addr / 4) % DEPTH;
        REQ_VALID  = 1'b1;
        REQ_WRITE  = wr;
        REQ_FUNCT3 = f3;
        REQ_ADDR   = addr;
        REQ_WDATA  = wdata;
        check_output({tag, ".ready"}, {31'h0, REQ_READY}, 32'h1);
        wc0 = write_count;
        @(posedge CLK);
        lat = 1;
        #1;
        if (!hold) REQ_VALID = 1'b0;
        while (!RESP_VALID && lat < 10) begin
            @(posedge CLK);
            lat++;
            #1;
        end
        check_output({tag, ".valid"}, {31'h0, RESP_VALID}, 32'h1);
        check_output({tag, ".latency"}, lat, exp_lat);
        check_output({tag, ".data"}, RESP_DATA, exp_data);
        check_output({tag, ".err"}, {31'h0, RESP_ERR}, {31'h0, exp_err});
        check_output({tag, ".writes"}, write_count - wc0, exp_writes);
        check_output({tag, ".ram"}, ram[idx], ref_mem[idx]);
        last_data = RESP_DATA;
    endtask

    initial begin
        int acc0, wc0;
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        RST_N = 1'b0;
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'b0;
        REQ_FUNCT3 = 3'b000;
        REQ_ADDR = 32'h0;
        REQ_WDATA = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        check_output("rst.valid", {31'h0, RESP_VALID}, 32'h0);
        check_output("rst.err", {31'h0, RESP_ERR}, 32'h0);
        check_output("rst.data", RESP_DATA, 32'h0);
        check_output("rst.ready", {31'h0, REQ_READY}, 32'h1);
        check_output("rst.mem_write", {31'h0, MEM_WRITE}, 32'h0);
        check_output("rst.mem_address", {22'h0, MEM_ADDRESS}, 32'h0);
        RST_N = 1'b1;

        // Give every word in the test window a known value.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus("init_sw", 1'b1, 3'b010, i * 4, $urandom(), 1'b0);
        end

        apply_stimulus("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        apply_stimulus("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        check_output("lw_10.const", last_data, 32'hDEADBEEF);

        apply_stimulus("sw_00", 1'b1, 3'b010, 32'h00, 32'h80FF7F01, 1'b0);
        apply_stimulus("lb_03", 1'b0, 3'b000, 32'h03, 32'h0, 1'b0);
        check_output("lb_03.const", last_data, 32'hFFFFFF80);
        apply_stimulus("lbu_03", 1'b0, 3'b100, 32'h03, 32'h0, 1'b0);
        check_output("lbu_03.const", last_data, 32'h00000080);
        apply_stimulus("lh_02", 1'b0, 3'b001, 32'h02, 32'h0, 1'b0);
        check_output("lh_02.const", last_data, 32'hFFFF80FF);
        apply_stimulus("lhu_00", 1'b0, 3'b101, 32'h00, 32'h0, 1'b0);
        check_output("lhu_00.const", last_data, 32'h00007F01);
        apply_stimulus("lb_00", 1'b0, 3'b000, 32'h00, 32'h0, 1'b0);
        check_output("lb_00.const", last_data, 32'h00000001);

        apply_stimulus("sw_20", 1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0);
        apply_stimulus("sb_21", 1'b1, 3'b000, 32'h21, 32'h000000AA, 1'b0);
        check_output("sb_21.const", ram[8], 32'h1122AA44);
        apply_stimulus("sh_22", 1'b1, 3'b001, 32'h22, 32'h0000BEEF, 1'b0);
        check_output("sh_22.const", ram[8], 32'hBEEFAA44);

        apply_stimulus("err_lw_06", 1'b0, 3'b010, 32'h06, 32'h0, 1'b0);
        apply_stimulus("err_sh_13", 1'b1, 3'b001, 32'h13, 32'h1234, 1'b0);
        apply_stimulus("err_f3_011", 1'b0, 3'b011, 32'h08, 32'h0, 1'b0);
        apply_stimulus("err_st_100", 1'b1, 3'b100, 32'h0C, 32'h55, 1'b0);

        // Reset sampled during the write cycle of an sb abandons it.
        wc0 = write_count;
        REQ_VALID = 1'b1;
        REQ_WRITE = 1'b1;
        REQ_FUNCT3 = 3'b000;
        REQ_ADDR = 32'h21;
        REQ_WDATA = 32'h00000055;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        @(posedge CLK);
        #1;
        check_output("abort.write_cycle", {31'h0, MEM_WRITE}, 32'h1);
        RST_N = 1'b0;
        #1;
        check_output("abort.write_gated", {31'h0, MEM_WRITE}, 32'h0);
        @(posedge CLK);
        #1;
        check_output("abort.valid", {31'h0, RESP_VALID}, 32'h0);
        check_output("abort.err", {31'h0, RESP_ERR}, 32'h0);
        check_output("abort.data", RESP_DATA, 32'h0);
        check_output("abort.mem_address", {22'h0, MEM_ADDRESS}, 32'h0);
        check_output("abort.mem_wdata", MEM_WDATA, 32'h0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check_output("abort.ready_after", {31'h0, REQ_READY}, 32'h1);
        check_output("abort.no_resp", {31'h0, RESP_VALID}, 32'h0);
        check_output("abort.writes", write_count - wc0, 0);
        check_output("abort.ram", ram[8], ref_mem[8]);

        // REQ_VALID held high across alternating sw/lw, including a wrap.
        acc0 = accept_count;
        for (int i = 0; i < 4; i++) begin
            d = $urandom();
            apply_stimulus("b2b_sw", 1'b1, 3'b010, 32'h1000 + i * 20, d, 1'b1);
            apply_stimulus("b2b_lw", 1'b0, 3'b010, i * 20, 32'h0, 1'b1);
            check_output("b2b_lw.data", last_data, d);
        end
        REQ_VALID = 1'b0;
        check_output("b2b.accepts", accept_count - acc0, 8);

        // Randomized mix, upper address bits random to exercise wrapping.
        for (int i = 0; i < 40; i++) begin
            apply_stimulus("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                           ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 63)),
                           $urandom(), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Load/store front-end between the pipeline MEM stage and the word-wide data RAM (synchronous write, combinational read, word-only writes).
- Accepts one byte-addressed request per transaction over a valid/ready handshake.
- Extracts and sign- or zero-extends loads.
- Implements byte/halfword stores by read-modify-write; flags misaligned or illegal accesses without touching RAM.

Parameters:
- ADDRESS_SIZE, 1024: RAM depth in 32-bit words. Local A_S = $clog2(ADDRESS_SIZE).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  synchronous active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  unit can accept; high only in IDLE.
- REQ_WRITE  in  1  1 = store, 0 = load.
- REQ_FUNCT3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data; low byte/half used for sb/sh.
- RESP_VALID  out  1  one-cycle completion pulse.
- RESP_DATA  out  32  extended load result; 0 for stores and errors.
- RESP_ERR  out  1  misaligned/illegal access, valid with RESP_VALID.
- MEM_ADDRESS  out  A_S  RAM word index.
- MEM_WRITE  out  1  RAM write enable.
- MEM_WDATA  out  32  RAM write data.
- MEM_RDATA  in  32  RAM combinational read data.

Behaviour:
- Reset (RST_N=0 at posedge):
  - state=IDLE.
  - RESP_VALID, RESP_ERR, RESP_DATA, registered address/data/merge registers = 0.
  - Reset abandons any in-flight transaction; no response is issued for it.
- MEM_WRITE = (state==WRITE) && RST_N, combinational. A write is suppressed at an edge where reset is sampled.
- Accept: REQ_VALID && REQ_READY at posedge T0. Register write, funct3, addr, wdata.
  - Next state: ERROR if illegal, else READ (loads, sb, sh) or WRITE (sw).
  - REQ_* ignored outside IDLE.
- MEM_ADDRESS = registered addr[A_S+1:2]. Upper address bits are ignored, so addresses wrap modulo RAM size.
- Illegal cases (→ ERROR):
  - funct3 ∈ {011,110,111}.
  - store with funct3[2]=1.
  - h/hu with addr[0]=1.
  - w with addr[1:0]≠00.
- States:
  - IDLE: REQ_READY=1.
  - READ, load: at next edge, select byte (addr[1:0]) or half (addr[1]) from MEM_RDATA, extend (b/h sign, bu/hu zero, w as-is), RESP_DATA<=result, RESP_VALID<=1, →IDLE.
  - READ, sb/sh: at next edge, capture MEM_RDATA into merge register, →WRITE.
  - WRITE: MEM_WDATA = merge register with the addressed byte/half replaced by wdata[7:0]/[15:0] (sw: wdata unchanged). RAM updates at next edge; RESP_VALID<=1, RESP_DATA<=0, →IDLE.
  - ERROR: no RAM access, MEM_WRITE=0. At next edge RESP_VALID<=1, RESP_ERR<=1, RESP_DATA<=0, →IDLE.
- RESP_VALID high exactly one cycle. It coincides with REQ_READY=1, so back-to-back requests are possible.
- RESP_ERR=0 on every non-error response. No response backpressure.
- Latency (edges from accept to RESP_VALID rising):
  - load 2.
  - sw 2.
  - sb/sh 3.
  - error 2.
- Store then load to the same word: the load observes the stored value, since RAM is updated before the next accept.

Test Plan:
- sw addr 0x10 data 0xDEADBEEF, then lw 0x10 → word 4 written; RESP_DATA=0xDEADBEEF, RESP_ERR=0, 2-edge latency each.
- Word 0x00 = 0x80FF7F01; lb 0x03 → 0xFFFFFF80; lbu 0x03 → 0x00000080; lh 0x02 → 0xFFFF80FF; lhu 0x00 → 0x00007F01; lb 0x00 → 0x00000001.
- Word 0x20 = 0x11223344; sb addr 0x21 data 0xAA → word 0x1122AA44 after 3 edges; sh addr 0x22 data 0xBEEF → 0xBEEFAA44; MEM_WRITE high exactly one cycle per store.
- lw 0x06, sh 0x13, funct3 011, store funct3 100 → each RESP_ERR=1, RESP_DATA=0, MEM_WRITE never asserted, RAM unchanged.
- RST_N=0 sampled during the WRITE cycle of an sb → no RAM change, no RESP_VALID, all outputs 0, REQ_READY=1 the cycle after reset releases.
- REQ_VALID held high with 8 alternating sw/lw requests → one accept per response, requests ignored while REQ_READY=0, addr 0x1000 wraps to word 0 (ADDRESS_SIZE=1024).
